// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the sequential divider.
// Master drives operands and start; slave returns status and results.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient,
    input  remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient,
    output remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero bypasses the iteration and completes in one cycle.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             zero_div;
  logic             last;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] shifted;

  assign accept   = bus.start &&
                    (state_q == IDLE ||
                     state_q == DONE);
  assign zero_div = (bus.divisor == '0);
  assign last     = (cnt_q == CW'(1));

  // sh_q holds unconsumed dividend bits above,
  // accumulated quotient bits below.
  assign diff    = {rem_q, sh_q[WIDTH-1]}
                 - {1'b0, dvs_q};
  assign shifted = {rem_q[WIDTH-2:0],
                    sh_q[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = zero_div ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
  end

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    sh_d  = sh_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    res_d = res_q;
    dbz_d = dbz_q;
    if (accept) begin
      dvs_d = bus.divisor;
      sh_d  = bus.dividend;
      rem_d = '0;
      dbz_d = 1'b0;
      if (zero_div) begin
        quo_d = '1;
        res_d = bus.dividend;
        dbz_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = CW'(WIDTH);
      end
    end else if (state_q == RUN) begin
      rem_d = diff[WIDTH] ? shifted
                          : diff[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], ~diff[WIDTH]};
      cnt_d = cnt_q - CW'(1);
      if (last) begin
        quo_d = sh_d;
        res_d = rem_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      sh_q  <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      res_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      sh_q  <= sh_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      res_q <= res_d;
      dbz_q <= dbz_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = res_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and swept checks of seq_divider at WIDTH 8 and 16.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(8))  b8();
  seq_divider_if #(.WIDTH(16)) b16();

  seq_divider #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  seq_divider #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  task automatic op8(
    input  logic [7:0] a, input logic [7:0] b,
    output int edges, output int busyc,
    output logic [7:0] q, output logic [7:0] r,
    output logic z, output logic one_cyc
  );
    @(negedge clk);
    b8.start = 1'b1; b8.dividend = a; b8.divisor = b;
    @(negedge clk);
    b8.start = 1'b0;
    edges = 1; busyc = 0;
    while (!b8.done && edges < 40) begin
      busyc += int'(b8.busy);
      @(negedge clk);
      edges++;
    end
    q = b8.quotient; r = b8.remainder; z = b8.div_by_zero;
    @(negedge clk);
    one_cyc = !b8.done;
  endtask

  task automatic op16(
    input  logic [15:0] a, input logic [15:0] b,
    output int edges, output int busyc,
    output logic [15:0] q, output logic [15:0] r,
    output logic z, output logic one_cyc
  );
    @(negedge clk);
    b16.start = 1'b1; b16.dividend = a; b16.divisor = b;
    @(negedge clk);
    b16.start = 1'b0;
    edges = 1; busyc = 0;
    while (!b16.done && edges < 60) begin
      busyc += int'(b16.busy);
      @(negedge clk);
      edges++;
    end
    q = b16.quotient; r = b16.remainder; z = b16.div_by_zero;
    @(negedge clk);
    one_cyc = !b16.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (b8.busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b expected 0", b8.busy);
    end
    if (b8.done !== 1'b0) begin
      errors++; $display("FAIL rst_done: got %b expected 0", b8.done);
    end
    if (b8.quotient !== 8'd0) begin
      errors++; $display("FAIL rst_quot: got %0d expected 0", b8.quotient);
    end
    if (b8.remainder !== 8'd0) begin
      errors++; $display("FAIL rst_rem: got %0d expected 0", b8.remainder);
    end
    if (b8.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL rst_dbz: got %b expected 0", b8.div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int e, bc; logic [7:0] q, r; logic z, oc;
    op8(8'd100, 8'd7, e, bc, q, r, z, oc);
    checks += 7;
    if (q !== 8'd14 || r !== 8'd2) begin
      errors++; $display("FAIL basic_result: got q=%0d r=%0d expected q=14 r=2", q, r);
    end
    if (z !== 1'b0) begin
      errors++; $display("FAIL basic_dbz: got %b expected 0", z);
    end
    if (e !== 9) begin
      errors++; $display("FAIL basic_latency: got %0d edges expected 9", e);
    end
    if (bc !== 8) begin
      errors++; $display("FAIL basic_busy: got %0d cycles expected 8", bc);
    end
    if (oc !== 1'b1) begin
      errors++; $display("FAIL basic_done_width: done still high, expected one cycle");
    end
    if (b8.quotient !== 8'd14 || b8.remainder !== 8'd2) begin
      errors++; $display("FAIL basic_hold: got q=%0d r=%0d expected q=14 r=2",
                         b8.quotient, b8.remainder);
    end
    @(negedge clk);
    if (b8.quotient !== 8'd14 || b8.busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: got q=%0d busy=%b expected q=14 busy=0",
                         b8.quotient, b8.busy);
    end
  endtask

  task automatic test_edges();
    int e, bc; logic [7:0] q, r; logic z, oc;
    op8(8'd255, 8'd1, e, bc, q, r, z, oc);
    checks += 2;
    if (q !== 8'd255 || r !== 8'd0) begin
      errors++; $display("FAIL div1_result: got q=%0d r=%0d expected q=255 r=0", q, r);
    end
    if (e !== 9) begin
      errors++; $display("FAIL div1_latency: got %0d expected 9", e);
    end
    op8(8'd5, 8'd9, e, bc, q, r, z, oc);
    checks += 2;
    if (q !== 8'd0 || r !== 8'd5) begin
      errors++; $display("FAIL small_result: got q=%0d r=%0d expected q=0 r=5", q, r);
    end
    if (e !== 9) begin
      errors++; $display("FAIL small_latency: got %0d expected 9", e);
    end
  endtask

  task automatic test_div_zero();
    int e, bc; logic [7:0] q, r; logic z, oc;
    op8(8'd42, 8'd0, e, bc, q, r, z, oc);
    checks += 5;
    if (q !== 8'hFF || r !== 8'd42) begin
      errors++; $display("FAIL dz_result: got q=%0h r=%0d expected q=ff r=42", q, r);
    end
    if (z !== 1'b1) begin
      errors++; $display("FAIL dz_flag: got %b expected 1", z);
    end
    if (e !== 1) begin
      errors++; $display("FAIL dz_latency: got %0d expected 1", e);
    end
    if (bc !== 0) begin
      errors++; $display("FAIL dz_busy: got %0d cycles expected 0", bc);
    end
    if (oc !== 1'b1 || b8.div_by_zero !== 1'b1) begin
      errors++; $display("FAIL dz_hold: got one_cyc=%b dbz=%b expected 1 1",
                         oc, b8.div_by_zero);
    end
  endtask

  task automatic test_ignore_run();
    int e;
    @(negedge clk);
    b8.start = 1'b1; b8.dividend = 8'd100; b8.divisor = 8'd7;
    @(negedge clk);
    e = 1;
    for (int i = 0; i < 4; i++) begin
      b8.start    = ~i[0];
      b8.dividend = 8'd3 + 8'(i);
      b8.divisor  = 8'd2;
      @(negedge clk);
      e++;
    end
    b8.start = 1'b0;
    while (!b8.done && e < 40) begin
      @(negedge clk);
      e++;
    end
    checks += 3;
    if (b8.quotient !== 8'd14 || b8.remainder !== 8'd2) begin
      errors++; $display("FAIL ignore_result: got q=%0d r=%0d expected q=14 r=2",
                         b8.quotient, b8.remainder);
    end
    if (b8.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL ignore_dbz_clear: got %b expected 0", b8.div_by_zero);
    end
    if (e !== 9) begin
      errors++; $display("FAIL ignore_latency: got %0d expected 9", e);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    @(negedge clk);
    b8.start = 1'b1; b8.dividend = 8'd100; b8.divisor = 8'd7;
    @(negedge clk);
    b8.dividend = 8'd200; b8.divisor = 8'd13;
    e = 1;
    while (!b8.done && e < 40) begin
      @(negedge clk);
      e++;
    end
    checks += 4;
    if (b8.quotient !== 8'd14 || b8.remainder !== 8'd2 || e !== 9) begin
      errors++; $display("FAIL b2b_first: got q=%0d r=%0d edges=%0d expected 14 2 9",
                         b8.quotient, b8.remainder, e);
    end
    @(negedge clk);
    if (b8.busy !== 1'b1 || b8.done !== 1'b0) begin
      errors++; $display("FAIL b2b_no_idle: got busy=%b done=%b expected 1 0",
                         b8.busy, b8.done);
    end
    b8.start = 1'b0;
    e = 1;
    while (!b8.done && e < 40) begin
      @(negedge clk);
      e++;
    end
    if (b8.quotient !== 8'd15 || b8.remainder !== 8'd5) begin
      errors++; $display("FAIL b2b_second: got q=%0d r=%0d expected q=15 r=5",
                         b8.quotient, b8.remainder);
    end
    if (e !== 9) begin
      errors++; $display("FAIL b2b_latency: got %0d expected 9", e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int e, bc; logic [7:0] q, r; logic z, oc;
    logic saw;
    @(negedge clk);
    b8.start = 1'b1; b8.dividend = 8'd100; b8.divisor = 8'd7;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (b8.busy !== 1'b0 || b8.done !== 1'b0) begin
      errors++; $display("FAIL mid_rst_status: got busy=%b done=%b expected 0 0",
                         b8.busy, b8.done);
    end
    if (b8.quotient !== 8'd0 || b8.remainder !== 8'd0 || b8.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL mid_rst_results: got q=%0d r=%0d dbz=%b expected 0 0 0",
                         b8.quotient, b8.remainder, b8.div_by_zero);
    end
    rst = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (b8.done) saw = 1'b1;
    end
    if (saw !== 1'b0) begin
      errors++; $display("FAIL mid_rst_no_done: got done pulse expected none");
    end
    op8(8'd200, 8'd13, e, bc, q, r, z, oc);
    if (q !== 8'd15 || r !== 8'd5 || e !== 9) begin
      errors++; $display("FAIL mid_rst_rerun: got q=%0d r=%0d edges=%0d expected 15 5 9",
                         q, r, e);
    end
  endtask

  task automatic test_random8();
    int e, bc, ee; logic [7:0] a, b, q, r, eq, er; logic z, oc;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      eq = (b == 0) ? 8'hFF : a / b;
      er = (b == 0) ? a : a % b;
      ee = (b == 0) ? 1 : 9;
      op8(a, b, e, bc, q, r, z, oc);
      checks++;
      if (q !== eq || r !== er || z !== (b == 0) || e !== ee || !oc) begin
        errors++;
        $display("FAIL rand8 %0d/%0d: got q=%0d r=%0d z=%b e=%0d oc=%b expected q=%0d r=%0d z=%b e=%0d oc=1",
                 a, b, q, r, z, e, oc, eq, er, (b == 0), ee);
      end
    end
  endtask

  task automatic test_w16();
    int e, bc, ee; logic [15:0] a, b, q, r, eq, er; logic z, oc;
    logic [15:0] va [4] = '{16'd1000, 16'd65535, 16'd3, 16'd500};
    logic [15:0] vb [4] = '{16'd7, 16'd255, 16'd40000, 16'd0};
    logic [15:0] vq [4] = '{16'd142, 16'd257, 16'd0, 16'hFFFF};
    logic [15:0] vr [4] = '{16'd6, 16'd0, 16'd3, 16'd500};
    for (int i = 0; i < 4; i++) begin
      op16(va[i], vb[i], e, bc, q, r, z, oc);
      ee = (vb[i] == 0) ? 1 : 17;
      checks += 2;
      if (q !== vq[i] || r !== vr[i] || z !== (vb[i] == 0)) begin
        errors++; $display("FAIL w16_dir%0d: got q=%0d r=%0d z=%b expected q=%0d r=%0d",
                           i, q, r, z, vq[i], vr[i]);
      end
      if (e !== ee || (vb[i] != 0 && bc !== 16) || !oc) begin
        errors++; $display("FAIL w16_timing%0d: got e=%0d busy=%0d oc=%b expected e=%0d",
                           i, e, bc, oc, ee);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = (i % 4 == 0) ? 16'($urandom_range(0, 255))
                       : 16'($urandom_range(0, 65535));
      eq = (b == 0) ? 16'hFFFF : a / b;
      er = (b == 0) ? a : a % b;
      ee = (b == 0) ? 1 : 17;
      op16(a, b, e, bc, q, r, z, oc);
      checks++;
      if (q !== eq || r !== er || z !== (b == 0) || e !== ee || !oc) begin
        errors++;
        $display("FAIL rand16 %0d/%0d: got q=%0d r=%0d z=%b e=%0d oc=%b expected q=%0d r=%0d e=%0d",
                 a, b, q, r, z, e, oc, eq, er, ee);
      end
    end
  endtask

  initial begin
    b8.start = 1'b0; b8.dividend = '0; b8.divisor = '0;
    b16.start = 1'b0; b16.dividend = '0; b16.divisor = '0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random8();
    test_w16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
